// File: rtl/button_event_capture_if.sv
// Event port between button_event_capture and the soft SoC.
//   evt_valid    : an event word is being held
//   evt_ready    : consumer takes the held word this cycle
//   evt_rise     : press mask of the held word
//   evt_fall     : release mask of the held word (zero unless releases are recorded)
//   evt_overflow : at least one edge was merged into an already-pending bit
// master = event producer, slave = consumer.
interface button_event_capture_if #(
  parameter int WIDTH = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;
  logic             evt_overflow;

  modport master (
    output evt_valid, evt_rise, evt_fall, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_rise, evt_fall, evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/button_event_capture.sv
// button_event_capture
//   Brings WIDTH asynchronous button levels into the clk domain, debounces
//   each one, turns accepted level changes into rise/fall pulses and queues
//   them as event words on a valid/ready port (one holding register plus an
//   accumulator for edges that arrive while the holding register is busy).
// Ports
//   clk        : fabric clock, all logic on posedge
//   resetn     : asynchronous active-low reset
//   btn_in     : raw button levels, 1 = pressed
//   btn_level  : debounced levels
//   evt        : event port (master side of button_event_capture_if)
// Build option
//   BUTTON_EVT_FALL_EN : when defined, release edges are queued as events.
//   When undefined, releases still update btn_level but never create an
//   event, never set overflow, and evt_fall stays 0.

// Per-button synchroniser + debouncer.
module button_event_capture_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CTR_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic level
);
  localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = btn_raw;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the synchronised input agrees with the accepted level
    // restarts the count; only an unbroken run of disagreement is accepted.
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

module button_event_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        btn_in,
  output logic [WIDTH-1:0]        btn_level,
  button_event_capture_if.master  evt
);
  localparam int CTR_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EW    = 2 * WIDTH;   // {rise, fall} event word width

  logic [WIDTH-1:0] level_w;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      button_event_capture_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CTR_W           (CTR_W)
      ) u_db (
        .clk     (clk),
        .resetn  (resetn),
        .btn_raw (btn_in[gi]),
        .level   (level_w[gi])
      );
    end
  endgenerate

  assign btn_level = level_w;

  // ---- edge detect: one-cycle pulses the cycle after btn_level changes ----
  logic [WIDTH-1:0] level_prev_q, level_prev_d;
  logic [WIDTH-1:0] rise_w, fall_w;

  assign level_prev_d = level_w;
  assign rise_w       = level_w & ~level_prev_q;
`ifdef BUTTON_EVT_FALL_EN
  assign fall_w       = ~level_w & level_prev_q;
`else
  assign fall_w       = '0;
`endif

  // ---- event queue: holding register + accumulator ----
  logic [EW-1:0]    acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             ovf_q, ovf_d;

  logic [EW-1:0]    new_w;
  logic [EW-1:0]    merged_w;
  logic             hit_w;
  logic             load_w;

  assign new_w    = {rise_w, fall_w};
  assign merged_w = acc_q | new_w;
  // A bit already pending in the accumulator that fires again is a lost edge.
  assign hit_w    = |(acc_q & new_w);
  assign load_w   = (!valid_q || evt.evt_ready) && (|merged_w);

  always_comb begin
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    valid_d   = valid_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    ovf_d     = ovf_q;
    if (load_w) begin
      // Output stage free (or being drained): pending + new edges move out
      // together so back-to-back events flow at one per cycle.
      valid_d   = 1'b1;
      rise_d    = merged_w[EW-1:WIDTH];
      fall_d    = merged_w[WIDTH-1:0];
      ovf_d     = acc_ovf_q | hit_w;
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end else if (valid_q && evt.evt_ready) begin
      // Drained with nothing behind it; payload returns to 0 while idle.
      valid_d   = 1'b0;
      rise_d    = '0;
      fall_d    = '0;
      ovf_d     = 1'b0;
    end else begin
      acc_d     = merged_w;
      acc_ovf_d = acc_ovf_q | hit_w;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_prev_q <= '0;
      acc_q        <= '0;
      acc_ovf_q    <= 1'b0;
      valid_q      <= 1'b0;
      rise_q       <= '0;
      fall_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      level_prev_q <= level_prev_d;
      acc_q        <= acc_d;
      acc_ovf_q    <= acc_ovf_d;
      valid_q      <= valid_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt.evt_valid    = valid_q;
  assign evt.evt_rise     = rise_q;
  assign evt.evt_overflow = ovf_q;
  // With releases disabled fall_w is constant 0, so fall_q and the fall half
  // of the accumulator only ever hold 0 and evt_fall is a constant 0.
  assign evt.evt_fall     = fall_q;
endmodule
